gcd_batch_requester: RTL and testbench

Initiator-side companion to the GCD unit: accepts a batch command (seed, count), drives `count` pseudo-random 16-bit operand pairs into a GCD unit's request interface, and consumes its 16-bit responses. It returns one 32-bit wrapping sum of all results. Sits between a test/host port and any GCD unit, all on val/rdy interfaces. Supports up to `p_max_inflight` outstanding requests.

---
 rtl/gcd_batch_pkg.sv | 38 +++
 rtl/gcd_lfsr16.sv | 34 +++
 rtl/gcd_batch_requester.sv | 134 +++++++++++++
 tb/tb_gcd_batch_requester.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_batch_pkg.sv
// Shared types and constants for the GCD batch requester and its LFSR.
// Message layouts are packed structs so the field boundaries live in one place.
package gcd_batch_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [15:0] LFSR_POLY      = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SEED = 16'hACE1;

  localparam int CMD_SEED_MSB  = 31;
  localparam int CMD_SEED_LSB  = 16;
  localparam int CMD_COUNT_MSB = 15;
  localparam int CMD_COUNT_LSB = 0;
  localparam int REQ_A_MSB     = 31;
  localparam int REQ_A_LSB     = 16;
  localparam int REQ_B_MSB     = 15;
  localparam int REQ_B_LSB     = 0;
  localparam int DONE_SUM_MSB  = 31;
  localparam int DONE_SUM_LSB  = 0;

  typedef struct packed {
    logic [15:0] seed;
    logic [15:0] count;
  } cmd_msg_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } req_msg_t;

  // One Galois step: shift right, fold the polynomial in when bit 0 falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/gcd_lfsr16.sv
// 16-bit Galois LFSR holding both the current state and the state one step ahead.
// Load takes one cycle; adv2 moves both registers two steps; no backpressure.
// Both outputs are flops, so {q, q_next} can drive a message port directly.
module gcd_lfsr16
  import gcd_batch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        adv2,
  output logic [15:0] q,
  output logic [15:0] q_next
);

  logic [15:0] seed_eff;

  // An all-zero state would lock up, so a zero seed is replaced.
  assign seed_eff = (load_val == 16'h0000) ? LFSR_ZERO_SEED : load_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= '0;
      q_next <= '0;
    end else if (load) begin
      q      <= seed_eff;
      q_next <= lfsr_step(seed_eff);
    end else if (adv2) begin
      q      <= lfsr_step(q_next);
      q_next <= lfsr_step(lfsr_step(q_next));
    end
  end

endmodule

// File: rtl/gcd_batch_requester.sv
// Issues a batch of pseudo-random operand pairs to a GCD unit and sums the results.
// First request one cycle after cmd_go; done one cycle after the final response.
// All valid/ready outputs come from registered state only; stalls hold messages.
module gcd_batch_requester
  import gcd_batch_pkg::*;
#(
  parameter int p_max_inflight = 2
)
(
  input  logic        clk,
  input  logic        reset,

  input  logic        cmd_val,
  output logic        cmd_rdy,
  input  logic [31:0] cmd_msg,

  output logic        req_val,
  input  logic        req_rdy,
  output logic [31:0] req_msg,

  input  logic        resp_val,
  output logic        resp_rdy,
  input  logic [15:0] resp_msg,

  output logic        done_val,
  input  logic        done_rdy,
  output logic [31:0] done_msg
);

  localparam int IW = $clog2(p_max_inflight + 1);
  localparam logic [IW-1:0] INFL_MAX = IW'(p_max_inflight);

  logic [1:0]    state;
  logic [15:0]   batch_count;
  logic [15:0]   issued;
  logic [15:0]   received;
  logic [IW-1:0] inflight;
  logic [31:0]   sum;

  logic [15:0]   lfsr_q;
  logic [15:0]   lfsr_q_next;

  cmd_msg_t      cmd;
  req_msg_t      req;
  logic          cmd_go;
  logic          req_go;
  logic          resp_go;
  logic          done_go;
  logic [15:0]   received_next;
  logic [IW-1:0] inflight_next;

  assign cmd = cmd_msg_t'(cmd_msg);

  assign cmd_rdy  = (state == ST_IDLE);
  assign req_val  = (state == ST_RUN) && (issued < batch_count) && (inflight < INFL_MAX);
  assign resp_rdy = (state == ST_RUN) && (inflight != '0);
  assign done_val = (state == ST_DONE);

  assign cmd_go  = cmd_val  && cmd_rdy;
  assign req_go  = req_val  && req_rdy;
  assign resp_go = resp_val && resp_rdy;
  assign done_go = done_val && done_rdy;

  assign req.a    = lfsr_q;
  assign req.b    = lfsr_q_next;
  assign req_msg  = req;
  assign done_msg = sum;

  assign received_next = received + {15'd0, resp_go};

  // Simultaneous issue and retire cancel out.
  always_comb begin
    inflight_next = inflight;
    case ({req_go, resp_go})
      2'b10:   inflight_next = inflight + IW'(1);
      2'b01:   inflight_next = inflight - IW'(1);
      default: inflight_next = inflight;
    endcase
  end

  gcd_lfsr16 u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (cmd_go),
    .load_val (cmd.seed),
    .adv2     (req_go),
    .q        (lfsr_q),
    .q_next   (lfsr_q_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      batch_count <= '0;
      issued      <= '0;
      received    <= '0;
      inflight    <= '0;
      sum         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_go) begin
            batch_count <= cmd.count;
            issued      <= '0;
            received    <= '0;
            inflight    <= '0;
            sum         <= '0;
            state       <= (cmd.count == 16'd0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (req_go) begin
            issued <= issued + 16'd1;
          end
          if (resp_go) begin
            received <= received_next;
            sum      <= sum + {16'd0, resp_msg};
          end
          inflight <= inflight_next;
          if (received_next == batch_count) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (done_go) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_batch_requester.sv
// Randomized bench for gcd_batch_requester with a delaying GCD sink and a reference model.
module tb_gcd_batch_requester;

  localparam int MAXI = 2;

  logic        clk;
  logic        reset;
  logic        cmd_val;
  logic        cmd_rdy;
  logic [31:0] cmd_msg;
  logic        req_val;
  logic        req_rdy;
  logic [31:0] req_msg;
  logic        resp_val;
  logic        resp_rdy;
  logic [15:0] resp_msg;
  logic        done_val;
  logic        done_rdy;
  logic [31:0] done_msg;

  int vectors;
  int miscompares;

  logic [15:0] sink_res[$];
  int          sink_due[$];

  gcd_batch_requester #(.p_max_inflight(MAXI)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_val  (cmd_val),
    .cmd_rdy  (cmd_rdy),
    .cmd_msg  (cmd_msg),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg),
    .done_val (done_val),
    .done_rdy (done_rdy),
    .done_msg (done_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] nxt(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] gcd16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] t;
    x = a;
    y = b;
    while (y != 16'h0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic run_batch(input string name, input logic [15:0] seed, input logic [15:0] cnt,
                           input int stall_pct, input int max_delay, input int done_hold,
                           output logic [31:0] got_sum, output logic [31:0] first_req,
                           output int same_cycles);
    logic [31:0] pairs[$];
    logic [15:0] s;
    logic [15:0] b;
    logic [31:0] exp_sum;
    logic        exp_rv;
    logic        exp_rr;
    logic        rgo;
    logic        sgo;
    int          niss;
    int          nrecv;
    int          infl;
    int          cyc;

    s = (seed == 16'h0) ? 16'hACE1 : seed;
    exp_sum = 32'h0;
    for (int i = 0; i < int'(cnt); i++) begin
      b = nxt(s);
      pairs.push_back({s, b});
      exp_sum += {16'h0, gcd16(s, b)};
      s = nxt(b);
    end
    niss = 0; nrecv = 0; infl = 0; cyc = 0; same_cycles = 0;
    got_sum = 32'h0; first_req = 32'h0;
    sink_res.delete();
    sink_due.delete();

    @(negedge clk);
    cmd_val = 1'b1; cmd_msg = {seed, cnt};
    vectors++;
    if (cmd_rdy !== 1'b1) begin
      miscompares++; $display("FAIL %s cmd_rdy_idle: got %b want 1", name, cmd_rdy);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_val = 1'b0;

    while (nrecv < int'(cnt) && cyc < 5000) begin
      req_rdy = 1'b0; resp_val = 1'b0;
      exp_rv = (niss < int'(cnt)) && (infl < MAXI);
      exp_rr = (infl > 0);
      vectors++;
      if (req_val !== exp_rv) begin
        miscompares++; $display("FAIL %s req_val cyc %0d: got %b want %b", name, cyc, req_val, exp_rv);
      end
      vectors++;
      if (resp_rdy !== exp_rr) begin
        miscompares++; $display("FAIL %s resp_rdy cyc %0d: got %b want %b", name, cyc, resp_rdy, exp_rr);
      end
      vectors++;
      if (cmd_rdy !== 1'b0 || done_val !== 1'b0) begin
        miscompares++; $display("FAIL %s busy_flags cyc %0d: cmd_rdy %b done_val %b want 0 0", name, cyc, cmd_rdy, done_val);
      end
      if (req_val === 1'b1 && niss < int'(cnt)) begin
        vectors++;
        if (req_msg !== pairs[niss]) begin
          miscompares++; $display("FAIL %s req_msg #%0d: got %h want %h", name, niss, req_msg, pairs[niss]);
        end
      end

      req_rdy = ($urandom_range(99) >= stall_pct);
      if (sink_res.size() > 0) begin
        resp_val = (sink_due[0] <= cyc) && ($urandom_range(3) != 0);
        resp_msg = sink_res[0];
      end else begin
        resp_val = $urandom_range(1) == 1;
        resp_msg = 16'($urandom);
      end
      #1;
      rgo = req_val && req_rdy;
      sgo = resp_val && resp_rdy;
      if (rgo && sgo) same_cycles++;
      if (sgo) begin
        void'(sink_res.pop_front());
        void'(sink_due.pop_front());
        nrecv++; infl--;
      end
      if (rgo) begin
        if (niss == 0) first_req = req_msg;
        sink_res.push_back(gcd16(req_msg[31:16], req_msg[15:0]));
        sink_due.push_back(cyc + 1 + int'($urandom_range(max_delay)));
        niss++; infl++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    req_rdy = 1'b0; resp_val = 1'b0;
    vectors++;
    if (nrecv != int'(cnt)) begin
      miscompares++; $display("FAIL %s timeout: received %0d want %0d", name, nrecv, cnt);
    end

    for (int h = 0; h <= done_hold; h++) begin
      vectors++;
      if (done_val !== 1'b1 || done_msg !== exp_sum) begin
        miscompares++; $display("FAIL %s done hold %0d: val %b msg %h want 1 %h", name, h, done_val, done_msg, exp_sum);
      end
      vectors++;
      if (cmd_rdy !== 1'b0 || req_val !== 1'b0 || resp_rdy !== 1'b0) begin
        miscompares++; $display("FAIL %s done_quiet %0d: cmd_rdy %b req_val %b resp_rdy %b want 0", name, h, cmd_rdy, req_val, resp_rdy);
      end
      got_sum = done_msg;
      done_rdy = (h == done_hold);
      @(posedge clk);
      @(negedge clk);
    end
    done_rdy = 1'b0;
    vectors++;
    if (cmd_rdy !== 1'b1 || done_val !== 1'b0) begin
      miscompares++; $display("FAIL %s back_to_idle: cmd_rdy %b done_val %b want 1 0", name, cmd_rdy, done_val);
    end
  endtask

  task automatic check_reset_values(input string name);
    vectors++;
    if (cmd_rdy !== 1'b1 || req_val !== 1'b0 || resp_rdy !== 1'b0 || done_val !== 1'b0) begin
      miscompares++; $display("FAIL %s flags: cmd_rdy %b req_val %b resp_rdy %b done_val %b want 1 0 0 0",
                              name, cmd_rdy, req_val, resp_rdy, done_val);
    end
    vectors++;
    if (done_msg !== 32'h0 || req_msg !== 32'h0) begin
      miscompares++; $display("FAIL %s msgs: done_msg %h req_msg %h want 0 0", name, done_msg, req_msg);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; cmd_val = 1'b0; cmd_msg = '0; req_rdy = 1'b0;
    resp_val = 1'b0; resp_msg = '0; done_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
  endtask

  task automatic test_basic;
    logic [31:0] sum, fr;
    int          same;
    run_batch("basic", 16'h0001, 16'd2, 0, 0, 0, sum, fr, same);
    vectors++;
    if (sum !== 32'h00002D01) begin
      miscompares++; $display("FAIL basic_sum: got %h want 00002d01", sum);
    end
    vectors++;
    if (fr !== 32'h0001B400) begin
      miscompares++; $display("FAIL basic_first_req: got %h want 0001b400", fr);
    end
  endtask

  task automatic test_zero_count;
    logic [31:0] sum, fr;
    int          same;
    run_batch("zero_count", 16'h1234, 16'd0, 0, 0, 0, sum, fr, same);
    vectors++;
    if (sum !== 32'h0) begin
      miscompares++; $display("FAIL zero_count_sum: got %h want 0", sum);
    end
  endtask

  task automatic test_seed_zero;
    logic [31:0] sum, fr;
    int          same;
    run_batch("seed_zero", 16'h0000, 16'd1, 0, 1, 0, sum, fr, same);
    vectors++;
    if (fr !== 32'hACE1E270) begin
      miscompares++; $display("FAIL seed_zero_first_req: got %h want ace1e270", fr);
    end
  endtask

  task automatic test_stalls;
    logic [31:0] sum, fr;
    logic [15:0] seed;
    int          same;
    seed = 16'($urandom);
    run_batch("stalls", seed, 16'd20, 50, 2, 5, sum, fr, same);
  endtask

  task automatic test_back_to_back;
    logic [31:0] sum, fr;
    logic [15:0] seed;
    int          same;
    seed = 16'($urandom);
    run_batch("back_to_back", seed, 16'd50, 0, 3, 1, sum, fr, same);
    vectors++;
    if (same == 0) begin
      miscompares++; $display("FAIL back_to_back_overlap: got %0d same-cycle req/resp want >0", same);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] sum, fr;
    int          same;
    @(negedge clk);
    cmd_val = 1'b1; cmd_msg = {16'h0001, 16'd3};
    req_rdy = 1'b1; resp_val = 1'b0; done_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_val = 1'b0;
    vectors++;
    if (req_val !== 1'b1) begin
      miscompares++; $display("FAIL midrun_first_req_val: got %b want 1", req_val);
    end
    @(posedge clk);
    @(negedge clk);
    req_rdy = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("midrun_reset");
    reset = 1'b0;
    run_batch("after_reset", 16'h0001, 16'd2, 20, 2, 1, sum, fr, same);
    vectors++;
    if (sum !== 32'h00002D01) begin
      miscompares++; $display("FAIL after_reset_sum: got %h want 00002d01", sum);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_zero_count();
    test_seed_zero();
    test_stalls();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
